// File: rtl/data_island_pkg.sv
// Shared HDMI data island constants, phase encodings and scheduler state type.
// The packet sources use the same length constants when building their packets.
package data_island_pkg;

    localparam int unsigned PreambleLen       = 8;
    localparam int unsigned GbLen             = 2;
    localparam int unsigned PacketLen         = 32;
    localparam int unsigned MaxPacketsDefault = 18;

    typedef enum logic [1:0] {
        PhPreamble = 2'd0,
        PhLeadGb   = 2'd1,
        PhPacket   = 2'd2,
        PhTrailGb  = 2'd3
    } phase_e;

    typedef enum logic [2:0] {
        StIdle,
        StPreamble,
        StLeadGb,
        StPacket,
        StTrailGb
    } state_e;

    // Increment a requester index, wrapping at n.
    function automatic logic [2:0] wrap_inc(input logic [2:0] i, input int unsigned n);
        return (({29'd0, i} + 32'd1) >= n) ? 3'd0 : i + 3'd1;
    endfunction

endpackage

// File: rtl/data_island_scheduler_rr_arbiter.sv
// Combinational round-robin picker: first asserted req at or after ptr, wrapping.
// The caller owns and advances the pointer.
module rr_arbiter #(
    parameter int unsigned NUM_REQ = 4
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [2:0]         ptr,
    output logic [NUM_REQ-1:0] winner,
    output logic [2:0]         idx,
    output logic               valid
);

    logic [NUM_REQ-1:0] rotated;
    logic [3:0]         pos;

    always_comb begin
        rotated = NUM_REQ'({req, req} >> ptr);
        winner  = '0;
        valid   = 1'b0;
        pos     = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (!valid && rotated[i]) begin
                valid = 1'b1;
                pos   = 4'(ptr) + 4'(i);
                if (pos >= 4'(NUM_REQ)) begin
                    pos = pos - 4'(NUM_REQ);
                end
            end
        end
        idx = pos[2:0];
        if (valid) begin
            winner = NUM_REQ'(1) << pos;
        end
    end

endmodule

// File: rtl/data_island_scheduler.sv
// Times HDMI data islands inside blanking and shares the packet serializer among
// NUM_REQ sources; every output is registered and changes on the state edge.
module data_island_scheduler
    import data_island_pkg::*;
#(
    parameter int unsigned NUM_REQ     = 4,
    parameter int unsigned MAX_PACKETS = MaxPacketsDefault,
    parameter int unsigned MIN_GAP     = 12,
    parameter int unsigned REMAIN_W    = 12
) (
    input  logic                pixelClock,
    input  logic                nReset,
    input  logic [REMAIN_W-1:0] blankRemaining,
    input  logic [NUM_REQ-1:0]  req,
    output logic [NUM_REQ-1:0]  grant,
    output logic [2:0]          selIdx,
    output logic                islandActive,
    output logic [1:0]          phase,
    output logic                isFirstPacketClock,
    output logic                isFirstIslandPacket,
    output logic [4:0]          charCount,
    output logic                overrun
);

    localparam logic [REMAIN_W-1:0] NeedFirst =
        REMAIN_W'(PreambleLen + GbLen + PacketLen + GbLen + MIN_GAP);
    localparam logic [REMAIN_W-1:0] NeedNext  = REMAIN_W'(PacketLen + GbLen + MIN_GAP);
    localparam int unsigned         CntW      = $clog2(MAX_PACKETS + 1);
    localparam logic [CntW-1:0]     LastPkt   = CntW'(MAX_PACKETS - 1);
    localparam logic [4:0]          PreLast   = 5'(PreambleLen - 1);
    localparam logic [4:0]          GbLast    = 5'(GbLen - 1);
    localparam logic [4:0]          PktLast   = 5'(PacketLen - 1);

    state_e             state;
    logic [2:0]         rr_ptr;
    logic [CntW-1:0]    pkt_cnt;
    logic [NUM_REQ-1:0] arb_winner;
    logic [2:0]         arb_idx;
    logic               arb_valid;
    logic               sel_req;

    rr_arbiter #(
        .NUM_REQ(NUM_REQ)
    ) u_rr_arbiter (
        .req   (req),
        .ptr   (rr_ptr),
        .winner(arb_winner),
        .idx   (arb_idx),
        .valid (arb_valid)
    );

    assign sel_req = |(req & (NUM_REQ'(1) << selIdx));

    always_ff @(posedge pixelClock or negedge nReset) begin
        if (!nReset) begin
            state               <= StIdle;
            rr_ptr              <= '0;
            pkt_cnt             <= '0;
            grant               <= '0;
            selIdx              <= '0;
            islandActive        <= 1'b0;
            phase               <= PhPreamble;
            isFirstPacketClock  <= 1'b0;
            isFirstIslandPacket <= 1'b0;
            charCount           <= '0;
            overrun             <= 1'b0;
        end else begin
            grant              <= '0;
            isFirstPacketClock <= 1'b0;
            if (islandActive && blankRemaining == '0) begin
                overrun <= 1'b1;
            end
            case (state)
                StIdle: begin
                    if (|req && blankRemaining >= NeedFirst) begin
                        state        <= StPreamble;
                        islandActive <= 1'b1;
                        phase        <= PhPreamble;
                        charCount    <= '0;
                        pkt_cnt      <= '0;
                    end
                end
                StPreamble: begin
                    if (charCount == PreLast) begin
                        if (arb_valid) begin
                            selIdx <= arb_idx;
                        end
                        state     <= StLeadGb;
                        phase     <= PhLeadGb;
                        charCount <= '0;
                    end else begin
                        charCount <= charCount + 5'd1;
                    end
                end
                StLeadGb: begin
                    if (charCount == GbLast) begin
                        // A withdrawn winner is replaced; with nobody left the
                        // previous source is held and must send a null packet.
                        if (!sel_req && arb_valid) begin
                            selIdx <= arb_idx;
                            grant  <= arb_winner;
                            rr_ptr <= wrap_inc(arb_idx, NUM_REQ);
                        end else begin
                            grant  <= NUM_REQ'(1) << selIdx;
                            rr_ptr <= wrap_inc(selIdx, NUM_REQ);
                        end
                        state               <= StPacket;
                        phase               <= PhPacket;
                        charCount           <= '0;
                        isFirstPacketClock  <= 1'b1;
                        isFirstIslandPacket <= 1'b1;
                    end else begin
                        charCount <= charCount + 5'd1;
                    end
                end
                StPacket: begin
                    if (charCount == PktLast) begin
                        isFirstIslandPacket <= 1'b0;
                        charCount           <= '0;
                        if (arb_valid && pkt_cnt < LastPkt && blankRemaining >= NeedNext) begin
                            selIdx             <= arb_idx;
                            grant              <= arb_winner;
                            rr_ptr             <= wrap_inc(arb_idx, NUM_REQ);
                            pkt_cnt            <= pkt_cnt + 1'b1;
                            isFirstPacketClock <= 1'b1;
                        end else begin
                            state <= StTrailGb;
                            phase <= PhTrailGb;
                        end
                    end else begin
                        charCount <= charCount + 5'd1;
                    end
                end
                StTrailGb: begin
                    if (charCount == GbLast) begin
                        state        <= StIdle;
                        phase        <= PhPreamble;
                        islandActive <= 1'b0;
                        charCount    <= '0;
                        pkt_cnt      <= '0;
                    end else begin
                        charCount <= charCount + 5'd1;
                    end
                end
                default: state <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_data_island_scheduler.sv
// Directed bench for data_island_scheduler: timing, round-robin order, thresholds,
// asynchronous reset and the sticky overrun flag.
module tb_data_island_scheduler;

    logic        pixelClock = 1'b0;
    logic        nReset;
    logic [11:0] blankRemaining;
    logic [3:0]  req;
    logic [3:0]  grant;
    logic [2:0]  selIdx;
    logic        islandActive;
    logic [1:0]  phase;
    logic        isFirstPacketClock;
    logic        isFirstIslandPacket;
    logic [4:0]  charCount;
    logic        overrun;

    int          tests = 0;
    int          fails = 0;
    bit          countdown = 1'b0;
    logic [3:0]  grant_log[$];
    int          rr_order[3] = '{0, 1, 3};

    data_island_scheduler dut (
        .pixelClock         (pixelClock),
        .nReset             (nReset),
        .blankRemaining     (blankRemaining),
        .req                (req),
        .grant              (grant),
        .selIdx             (selIdx),
        .islandActive       (islandActive),
        .phase              (phase),
        .isFirstPacketClock (isFirstPacketClock),
        .isFirstIslandPacket(isFirstIslandPacket),
        .charCount          (charCount),
        .overrun            (overrun)
    );

    always #5 pixelClock = ~pixelClock;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        assert (got === exp)
        else begin
            fails++;
            $error("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Advance n clock edges, sampling 1 time unit after each edge.
    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge pixelClock);
            #1;
            if (grant != '0) grant_log.push_back(grant);
            if (countdown && blankRemaining != '0) blankRemaining = blankRemaining - 12'd1;
        end
    endtask

    task automatic do_reset();
        nReset         = 1'b0;
        req            = '0;
        blankRemaining = '0;
        countdown      = 1'b0;
        @(posedge pixelClock);
        #1;
        nReset = 1'b1;
        grant_log.delete();
    endtask

    initial begin
        nReset         = 1'b1;
        req            = '0;
        blankRemaining = '0;
        #1 nReset = 1'b0;
        @(posedge pixelClock);
        #1;
        check("reset_outputs", 32'({grant, selIdx, islandActive, phase, isFirstPacketClock,
                                    isFirstIslandPacket, charCount, overrun}), 0);
        nReset = 1'b1;

        // 1: single source with blanking counting down from 200
        do_reset();
        req = 4'b0001; blankRemaining = 12'd200; countdown = 1'b1;
        tick(1);
        check("t1_start_active", 32'(islandActive), 1);
        check("t1_start_phase", 32'(phase), 0);
        tick(7);
        check("t1_pre_last_cc", 32'(charCount), 7);
        tick(1);
        check("t1_lead_phase", 32'(phase), 1);
        tick(1);
        check("t1_lead_cc1", 32'(charCount), 1);
        check("t1_no_early_grant", 32'(grant_log.size()), 0);
        tick(1);
        check("t1_grant_c11", 32'(grant), 32'h1);
        check("t1_first_pkt_clk", 32'(isFirstPacketClock), 1);
        check("t1_first_isl_pkt", 32'(isFirstIslandPacket), 1);
        check("t1_pkt_phase", 32'({phase, charCount}), 32'({2'd2, 5'd0}));
        tick(1);
        check("t1_fpc_pulse", 32'({isFirstPacketClock, isFirstIslandPacket}), 32'b01);
        tick(31);
        check("t1_pkt2_start", 32'({phase, charCount, isFirstPacketClock}), 32'({2'd2, 5'd0, 1'b1}));
        check("t1_pkt2_not_first", 32'(isFirstIslandPacket), 0);
        tick(128);
        check("t1_trail_c0", 32'({phase, charCount}), 32'({2'd3, 5'd0}));
        check("t1_packets", 32'(grant_log.size()), 5);
        tick(1);
        check("t1_trail_c1", 32'({phase, charCount}), 32'({2'd3, 5'd1}));
        tick(1);
        check("t1_end_idle", 32'({islandActive, phase}), 0);
        tick(2);
        check("t1_no_restart", 32'(islandActive), 0);
        check("t1_no_overrun", 32'(overrun), 0);

        // 2: round-robin across 0,1,3 capped at 18 packets
        do_reset();
        req = 4'b1011; blankRemaining = 12'd1000;
        tick(587);
        check("t2_trail_c0", 32'({phase, charCount}), 32'({2'd3, 5'd0}));
        check("t2_packets", 32'(grant_log.size()), 18);
        for (int i = 0; i < grant_log.size(); i++) begin
            check($sformatf("t2_grant%0d", i), 32'(grant_log[i]), 32'(4'b0001 << rr_order[i % 3]));
        end
        tick(1);
        check("t2_trail_c1", 32'({islandActive, phase, charCount}), 32'({1'b1, 2'd3, 5'd1}));
        tick(1);
        check("t2_idle", 32'(islandActive), 0);
        tick(1);
        check("t2_restart", 32'(islandActive), 1);

        // 3: start threshold
        do_reset();
        req = 4'b0001; blankRemaining = 12'd55;
        tick(3);
        check("t3_below_thresh", 32'(islandActive), 0);
        blankRemaining = 12'd56;
        tick(1);
        check("t3_at_thresh", 32'({islandActive, phase, charCount}), 32'({1'b1, 2'd0, 5'd0}));

        // 4: continuation threshold
        do_reset();
        req = 4'b0001; blankRemaining = 12'd200;
        tick(42);
        check("t4a_c31", 32'({phase, charCount}), 32'({2'd2, 5'd31}));
        blankRemaining = 12'd45;
        tick(1);
        check("t4a_trail", 32'({islandActive, phase, charCount}), 32'({1'b1, 2'd3, 5'd0}));
        check("t4a_one_grant", 32'(grant_log.size()), 1);
        do_reset();
        req = 4'b0001; blankRemaining = 12'd200;
        tick(42);
        blankRemaining = 12'd46;
        tick(1);
        check("t4b_next_pkt", 32'({phase, charCount, isFirstPacketClock}), 32'({2'd2, 5'd0, 1'b1}));
        check("t4b_grant", 32'(grant), 32'h1);

        // 5: asynchronous reset mid-packet, pointer returns to 0
        do_reset();
        req = 4'b0001; blankRemaining = 12'd200;
        tick(26);
        check("t5_c15", 32'({phase, charCount}), 32'({2'd2, 5'd15}));
        req    = 4'b0011;
        nReset = 1'b0;
        #1;
        check("t5_async_clear", 32'({grant, selIdx, islandActive, phase, isFirstPacketClock,
                                     isFirstIslandPacket, charCount, overrun}), 0);
        @(posedge pixelClock);
        #1;
        nReset = 1'b1;
        check("t5_idle_after", 32'(islandActive), 0);
        tick(11);
        check("t5_ptr_zero", 32'({grant, selIdx}), 32'({4'b0001, 3'd0}));

        // 6: blanking collapses to 0 mid-packet
        do_reset();
        req = 4'b0001; blankRemaining = 12'd200;
        tick(20);
        check("t6_pre_overrun", 32'(overrun), 0);
        blankRemaining = 12'd0;
        tick(1);
        check("t6_overrun_set", 32'(overrun), 1);
        tick(22);
        check("t6_trail_c0", 32'({phase, charCount}), 32'({2'd3, 5'd0}));
        tick(1);
        check("t6_trail_c1", 32'({islandActive, phase, charCount}), 32'({1'b1, 2'd3, 5'd1}));
        tick(1);
        check("t6_idle", 32'(islandActive), 0);
        tick(2);
        check("t6_sticky", 32'({overrun, islandActive}), 32'b10);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/data_island_scheduler.md
Name: data_island_scheduler

Overview:
- Owns the timing of every HDMI data island period on a link and shares the packet serializer between N packet sources, e.g. HBlank audio/clock-regen and VBlank infoframes.
- Each cycle it decides whether an island (preamble, leading guard band, 1..MAX_PACKETS packets, trailing guard band) fits in the blanking that remains.
- It grants packet slots round-robin and drives the phase/select signals that the channel mux and the serializer consume.
- It sits between the video timing generator and the HDMI encoder's channel mux.

Parameters:
- NUM_REQ, 4, number of packet requesters (2..8).
- MAX_PACKETS, 18, maximum packets per island (HDMI limit).
- MIN_GAP, 12, control-period characters required after the trailing guard band before active video.
- REMAIN_W, 12, width of the blankRemaining counter.

Ports:
- pixelClock  in  1  pixel/character clock.
- nReset  in  1  asynchronous, active-low reset.
- blankRemaining  in  REMAIN_W  characters left before next active video; 0 during active video.
- req  in  NUM_REQ  level request per source; held until granted.
- grant  out  NUM_REQ  one-hot, one-cycle pulse on the first character of the granted packet.
- selIdx  out  3  index of the source being serialized; stable for all 32 packet characters.
- islandActive  out  1  high from first preamble character through last trailing guard band character.
- phase  out  2  0=preamble, 1=leading guard band, 2=packet, 3=trailing guard band; 0 when idle.
- isFirstPacketClock  out  1  high on character 0 of each packet (serializer restart).
- isFirstIslandPacket  out  1  high during the first packet of an island.
- charCount  out  5  character index within the current phase.
- overrun  out  1  sticky error flag.

Behaviour:
- Reset (asynchronous, nReset=0):
  - State=IDLE; all outputs 0; rrPtr=0; packet counter 0.
  - Reset mid-island aborts immediately; no trailing guard band is emitted.
- Constants:
  - NEED_FIRST = 8+2+32+2+MIN_GAP.
  - NEED_NEXT = 32+2+MIN_GAP.
  - Comparisons are unsigned against blankRemaining, sampled on the current cycle.
- Arbitration:
  - Round-robin over req, starting the search at rrPtr.
  - The winner is registered into selIdx on the cycle before its packet begins.
  - After each grant, rrPtr = winner+1 (mod NUM_REQ).
  - A source that drops req before being chosen loses nothing; it simply is not selected.
- States (all registered outputs change on the state edge):
  - IDLE:
    - If |req and blankRemaining >= NEED_FIRST: go to PREAMBLE, charCount=0, islandActive=1.
    - Otherwise stay.
  - PREAMBLE: 8 characters (charCount 0..7), phase=0. On charCount==7, register the winner, go to LEAD_GB.
  - LEAD_GB:
    - 2 characters, phase=1.
    - If the winner's req has dropped by the last character, the next req winner is taken.
    - If no req is left, a packet is still issued with selIdx unchanged. The source must supply a null packet (type 0x00); this is a documented requester contract.
  - PACKET:
    - 32 characters, phase=2.
    - At character 0: grant[selIdx]=1 and isFirstPacketClock=1.
    - isFirstIslandPacket=1 for the first packet only.
    - At character 31, continue with another PACKET (register the next winner) only if all hold: |req, packetCount+1 < MAX_PACKETS, blankRemaining >= NEED_NEXT.
    - Otherwise go to TRAIL_GB.
  - TRAIL_GB: 2 characters, phase=3, then IDLE with islandActive=0 and the packet counter cleared.
- The earliest possible restart is on the cycle after TRAIL_GB ends.
  - The controller's margin already includes MIN_GAP.
  - Islands are not back-to-back within the same blanking unless the remaining blanking permits.
- Simultaneous req rise and blankRemaining falling below the threshold: the threshold wins; stay IDLE.
- overrun:
  - Set when islandActive=1 and blankRemaining==0 (timing input violated its contract).
  - Cleared only by reset.
  - The island always completes its current phase sequence normally.

Decomposition:
- Shared package data_island_pkg holds:
  - Phase encodings and state enum.
  - Preamble length (8), guard-band length (2), packet length (32), MAX_PACKETS default.
  - These constants are also used by the HBlank/VBlank packet sources.
- One sub-module: rr_arbiter, a parameterised round-robin picker.
  - Inputs: req and ptr.
  - Outputs: one-hot winner, index, valid.
  - Purely combinational; the scheduler owns the pointer register.

Test Plan:
1. Single source: req=4'b0001 held, blankRemaining=200 → 8 preamble + 2 guard band, grant[0] pulse at cycle 11 (isFirstPacketClock=1), 32 packet characters. Because req stays held, packets repeat until blankRemaining < NEED_NEXT, then 2 trailing guard band characters and islandActive low.
2. Round-robin: req=4'b1011 held, blankRemaining=1000 → grants 0,1,3,0,... one per 32 characters. Island ends after exactly 18 packets (MAX_PACKETS) with trailing guard band.
3. Threshold boundary: blankRemaining=NEED_FIRST-1 with req=1 → stays IDLE. blankRemaining=NEED_FIRST=56 → island starts the next cycle.
4. Continuation boundary: blankRemaining equals 45 at packet character 31 → trailing guard band; equals 46 (NEED_NEXT) → second packet.
5. Asynchronous reset mid-packet (charCount=15): nReset low → all outputs 0 immediately; after release, IDLE with rrPtr=0.
6. Overrun: force blankRemaining=0 during PACKET → overrun=1 persists after island end; island still emits 2 trailing guard band characters.
